// File: rtl/led_blink_tx_if.sv
// Request/status bundle for the LED blink sequencer.
// The master side issues blink requests; the slave side is the sequencer.
interface led_blink_tx_if #(
  parameter int CNT_W = 4
);
  logic             i_valid;
  logic [CNT_W-1:0] i_count;
  logic             i_abort;
  logic             o_ready;
  logic             LED1;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_valid, i_count, i_abort,
    input  o_ready, LED1, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_count, i_abort,
    output o_ready, LED1, o_busy, o_done
  );
endinterface

// File: rtl/led_blink_tx.sv
// Blinks LED1 a requested number of times: ON_CYCLES lit, OFF_CYCLES dark per blink,
// then a one-cycle o_done pulse. i_abort cancels silently at any edge.
module led_blink_tx #(
  parameter int ON_CYCLES  = 12000000,
  parameter int OFF_CYCLES = 12000000,
  parameter int CNT_W      = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  led_blink_tx_if.slave  bus
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int PH_W    = $clog2(MAX_CYC) + 1;

  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_CYCLES - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic             led_q,   led_d;
  logic             done_q,  done_d;

  logic ready;
  logic accept;

  // Gating with RST_N keeps o_ready low for the whole reset window even though
  // the state register already reads IDLE.
  assign ready  = (state_q == ST_IDLE) && !bus.i_abort && RST_N;
  assign accept = bus.i_valid && ready;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (accept) begin
          rem_d = bus.i_count;
          if (bus.i_count != '0) begin
            state_d = ST_ON;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_ON: begin
        if (phase_q == ON_LAST) begin
          state_d = ST_OFF;
          phase_d = '0;
          rem_d   = (rem_q != '0) ? rem_q - CNT_W'(1) : '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      ST_OFF: begin
        if (phase_q == OFF_LAST) begin
          phase_d = '0;
          if (rem_q != '0) begin
            state_d = ST_ON;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        rem_d   = '0;
      end
    endcase

    // Abort overrides everything, including a completion that would land this edge.
    if (bus.i_abort) begin
      state_d = ST_IDLE;
      phase_d = '0;
      rem_d   = '0;
      done_d  = 1'b0;
    end

    led_d = (state_d == ST_ON);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      rem_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.LED1    = led_q;
  assign bus.o_busy  = (state_q != ST_IDLE);
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_led_blink_tx.sv
// Bench for led_blink_tx: queue-based expected-waveform model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_led_blink_tx;

  localparam int ON_C  = 3;
  localparam int OFF_C = 2;
  localparam int CW    = 4;

  logic CLK;
  logic RST_N;

  led_blink_tx_if #(.CNT_W(CW)) bus();

  led_blink_tx #(
    .ON_CYCLES (ON_C),
    .OFF_CYCLES(OFF_C),
    .CNT_W     (CW)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs per cycle; a sequence is planned as a list of future cycles.
  typedef struct packed {
    logic led;
    logic busy;
    logic done;
  } exp_t;

  exp_t cur = '0;
  exp_t fut[$];

  function automatic void plan(input int n);
    exp_t e;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < ON_C; i++) begin
        e = '{led: 1'b1, busy: 1'b1, done: 1'b0};
        fut.push_back(e);
      end
      for (int i = 0; i < OFF_C; i++) begin
        e = '{led: 1'b0, busy: 1'b1, done: 1'b0};
        fut.push_back(e);
      end
    end
    e = '{led: 1'b0, busy: 1'b0, done: 1'b1};
    fut.push_back(e);
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fut.delete();
      cur = '0;
    end else if (bus.i_abort) begin
      fut.delete();
      cur = '0;
    end else begin
      if (!cur.busy && bus.i_valid) begin
        fut.delete();
        plan(int'(bus.i_count));
      end
      if (fut.size() > 0) cur = fut.pop_front();
      else                cur = '0;
    end
  end

  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      check("cyc_led",   bus.LED1,    cur.led);
      check("cyc_busy",  bus.o_busy,  cur.busy);
      check("cyc_done",  bus.o_done,  cur.done);
      check("cyc_ready", bus.o_ready, (!cur.busy && !bus.i_abort));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int k = 0;
    bus.i_valid = 1'b0;
    bus.i_abort = 1'b0;
    while (cur.busy && k < 400) begin
      @(posedge CLK); #1;
      k++;
    end
    @(posedge CLK); #1;
    check("idle_bound", (k < 400), 1);
    check("idle_busy", bus.o_busy, 0);
  endtask

  initial begin
    logic [9:0]  led_tr;
    logic [11:0] b2b_led;
    logic [11:0] b2b_done;
    logic [4:0]  led5;
    int busy_cnt;
    int done_cnt;
    int ons;
    logic prev;

    RST_N       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_count = '0;
    bus.i_abort = 1'b0;

    // Reset state, before any clock activity matters
    #12;
    check("rst_led",   bus.LED1,    0);
    check("rst_busy",  bus.o_busy,  0);
    check("rst_done",  bus.o_done,  0);
    check("rst_ready", bus.o_ready, 0);
    @(negedge CLK); #2;
    RST_N = 1'b1;
    #1;
    check("ready_after_rst", bus.o_ready, 1);

    // Two blinks, request held one cycle; i_count scrambled afterwards
    wait_idle();
    bus.i_valid = 1'b1;
    bus.i_count = 4'd2;
    @(posedge CLK); #1;
    bus.i_valid = 1'b0;
    bus.i_count = CW'($urandom);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      led_tr[9-i] = bus.LED1;
      busy_cnt += int'(bus.o_busy);
      done_cnt += int'(bus.o_done);
    end
    check("c2_led_pattern", led_tr, 10'b1110011100);
    check("c2_busy_cycles", busy_cnt, 10);
    check("c2_no_early_done", done_cnt, 0);
    @(negedge CLK);
    check("c2_done", bus.o_done, 1);
    check("c2_idle", bus.o_busy, 0);
    check("c2_ready_in_done", bus.o_ready, 1);

    // Zero-blink request
    wait_idle();
    bus.i_valid = 1'b1;
    bus.i_count = 4'd0;
    @(posedge CLK); #1;
    bus.i_valid = 1'b0;
    @(negedge CLK);
    check("c0_done", bus.o_done, 1);
    check("c0_led",  bus.LED1,   0);
    check("c0_busy", bus.o_busy, 0);
    @(negedge CLK);
    check("c0_done_once", bus.o_done, 0);

    // Abort (together with a new request) during the second ON phase of three
    wait_idle();
    bus.i_valid = 1'b1;
    bus.i_count = 4'd3;
    @(posedge CLK); #1;
    bus.i_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("ab_on2_lit", bus.LED1, 1);
    bus.i_abort = 1'b1;
    bus.i_valid = 1'b1;
    @(posedge CLK); #1;
    check("ab_led",   bus.LED1,    0);
    check("ab_busy",  bus.o_busy,  0);
    check("ab_done",  bus.o_done,  0);
    check("ab_ready", bus.o_ready, 0);
    bus.i_abort = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    check("ab_ready_after", bus.o_ready, 1);
    done_cnt = 0;
    repeat (8) begin
      @(negedge CLK);
      done_cnt += int'(bus.o_done);
    end
    check("ab_no_done", done_cnt, 0);

    // Request held high: back-to-back single blinks
    wait_idle();
    bus.i_valid = 1'b1;
    bus.i_count = 4'd1;
    @(posedge CLK);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      b2b_led[11-i]  = bus.LED1;
      b2b_done[11-i] = bus.o_done;
    end
    bus.i_valid = 1'b0;
    check("b2b_led",  b2b_led,  12'b111000111000);
    check("b2b_done", b2b_done, 12'b000001000001);

    // Asynchronous reset in the middle of an ON phase
    wait_idle();
    bus.i_valid = 1'b1;
    bus.i_count = 4'd1;
    @(posedge CLK); #1;
    bus.i_valid = 1'b0;
    @(posedge CLK); #3;
    check("ar_lit_before", bus.LED1, 1);
    RST_N = 1'b0;
    #1;
    check("ar_led",   bus.LED1,    0);
    check("ar_busy",  bus.o_busy,  0);
    check("ar_done",  bus.o_done,  0);
    check("ar_ready", bus.o_ready, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); #2;
    RST_N = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_count = 4'd1;
    #1;
    check("ar_ready_release", bus.o_ready, 1);
    @(posedge CLK); #1;
    bus.i_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      led5[4-i] = bus.LED1;
    end
    check("ar_c1_pattern", led5, 5'b11100);
    @(negedge CLK);
    check("ar_c1_done", bus.o_done, 1);

    // Maximum count: fifteen blinks then a single done
    wait_idle();
    bus.i_valid = 1'b1;
    bus.i_count = 4'd15;
    @(posedge CLK); #1;
    bus.i_valid = 1'b0;
    prev = 1'b0;
    ons = 0;
    done_cnt = 0;
    for (int k = 0; k < 200 && done_cnt == 0; k++) begin
      @(negedge CLK);
      if (bus.LED1 && !prev) ons++;
      prev = bus.LED1;
      done_cnt += int'(bus.o_done);
    end
    check("c15_on_phases", ons, 15);
    check("c15_done", done_cnt, 1);
    @(negedge CLK);
    check("c15_done_once", bus.o_done, 0);

    // Random traffic against the model
    wait_idle();
    repeat (3000) begin
      @(posedge CLK); #1;
      bus.i_valid = (($urandom % 4) == 0);
      bus.i_count = (($urandom % 16) == 0) ? 4'd15 : CW'($urandom % 4);
      bus.i_abort = (($urandom % 50) == 0);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_blink_tx.md
LED_BLINK_TX -- requirements
Module: led_blink_tx

Interface
REQ-001 Parameter ON_CYCLES, default 12000000, SHALL set the LED-on phase length in CLK cycles (legal range >= 1).
REQ-002 Parameter OFF_CYCLES, default 12000000, SHALL set the LED-off phase length in CLK cycles (legal range >= 1).
REQ-003 Parameter CNT_W, default 4, SHALL set the width of the blink-count request.
REQ-004 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 RST_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 i_valid  input  1  SHALL be the request strobe, qualified by o_ready.
REQ-007 i_count  input  CNT_W  SHALL be the number of blinks requested, sampled on acceptance.
REQ-008 i_abort  input  1  SHALL be a synchronous cancel of any sequence in progress.
REQ-009 o_ready  output  1  SHALL be high when a request can be accepted.
REQ-010 LED1  output  1  SHALL be the registered LED drive, 1 = lit.
REQ-011 o_busy  output  1  SHALL be high while a sequence is in progress (state not IDLE).
REQ-012 o_done  output  1  SHALL be a one-cycle pulse marking normal completion of a sequence.

Function
REQ-013 The block SHALL use three states: IDLE, ON, OFF.
REQ-014 o_ready SHALL equal (state == IDLE) AND NOT i_abort.
REQ-015 A request SHALL be accepted on a rising edge where i_valid and o_ready are both 1; i_count is latched into a remaining-blinks counter at that edge.
REQ-016 Acceptance with i_count != 0 SHALL move IDLE -> ON, so that LED1 = 1 from the next cycle onward (latency 1 cycle).
REQ-017 Acceptance with i_count == 0 SHALL keep the state at IDLE, pulse o_done in the following cycle, and leave LED1 low.
REQ-018 In ON, LED1 SHALL be 1 for exactly ON_CYCLES cycles, then the state moves ON -> OFF and the remaining-blinks counter decrements by 1.
REQ-019 In OFF, LED1 SHALL be 0 for exactly OFF_CYCLES cycles; at the end, the state moves to ON if the counter is nonzero, otherwise to IDLE.
REQ-020 The OFF -> IDLE transition SHALL assert o_done for exactly the first cycle in IDLE; o_ready is also high in that cycle.
REQ-021 The phase counter SHALL be sized to clog2(max(ON_CYCLES, OFF_CYCLES)) + 1 bits, SHALL reload to 0 on every state change, and SHALL never wrap within a phase.
REQ-022 i_valid SHALL be ignored while o_ready = 0; no request is queued.
REQ-023 i_count SHALL be ignored outside the accepting edge; changes mid-sequence have no effect.
REQ-024 i_abort = 1 at any edge SHALL force the state to IDLE, LED1 = 0, and the counters to 0, with no o_done pulse.
REQ-025 i_abort and i_valid asserted together SHALL result in abort: the request is not accepted.
REQ-026 A request accepted in the o_done cycle SHALL start a new sequence with no extra idle cycle.
REQ-027 i_count = all-ones SHALL produce 2^CNT_W - 1 blinks; the remaining-blinks counter SHALL not underflow.

Reset
REQ-028 RST_N low SHALL immediately, without waiting for CLK, force state = IDLE, LED1 = 0, o_busy = 0, o_done = 0, and all counters = 0.
REQ-029 o_ready SHALL be 0 while RST_N is low, and 1 from release onward when i_abort = 0.
REQ-030 Reset asserted mid-sequence SHALL discard the sequence without an o_done pulse.
REQ-031 After RST_N rises, the first request SHALL be acceptable at the first rising edge.

Verification (ON_CYCLES=3, OFF_CYCLES=2, CNT_W=4)
REQ-032 i_count=2, valid for 1 cycle -> LED1 pattern 1,1,1,0,0,1,1,1,0,0; then o_done for 1 cycle; o_busy high for 10 cycles.
REQ-033 i_count=0 accepted -> o_done pulse on the next cycle, LED1 stays 0, o_busy stays 0.
REQ-034 i_count=3 started, i_abort pulsed during the 2nd ON phase -> LED1=0 and o_busy=0 the next cycle, no o_done, o_ready=1 after i_abort drops.
REQ-035 i_valid held high with i_count=1 throughout -> back-to-back sequences, each 1,1,1,0,0, with o_done between them and no idle gap.
REQ-036 RST_N pulled low asynchronously mid-ON -> LED1=0 before the next CLK edge; after release, i_count=1 runs normally.
REQ-037 i_count=15 -> exactly 15 ON phases are counted, then a single o_done.
